// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file types and defaults for decode, hazard unit and regfile
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_idx_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;

  localparam reg_idx_t REG_ZERO = '0;

  // x0 is architecturally constant; every path that writes or tracks state must skip it
  function automatic logic is_reg_zero(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with flush > alloc > write-clear priority
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              flush,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Next busy state: flush clears everything, otherwise writebacks clear and an allocation
  // applied afterwards so it wins over a same-cycle writeback to the same register.
  always_comb begin
    busy_nxt = busy_q;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w]) begin
          busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en) begin
        busy_nxt[alloc_addr] = 1'b1;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy bit storage; x0 never becomes busy because busy_nxt[0] is forced low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port RV32I register file with busy scoreboard (optional RF_WRITE_BYPASS_EN)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] regs [NREGS];

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  // Storage writes; ports are visited in index order so the highest port wins a collision.
  // The x0 gate is on the address only, a zero data value is an ordinary write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read ports; x0 reads as zero and never busy. With bypass enabled a
  // same-cycle writeback is forwarded and treated as no longer pending.
  always_comb begin : read_mux
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = rd_addr[p*AW +: AW];
      if (ra != '0) begin
        rd_data[p*XLEN +: XLEN] = regs[ra];
        rd_busy[p]              = busy_vec[ra];
`ifdef RF_WRITE_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
            rd_busy[p]              = alloc_en && (alloc_addr == ra);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (directed plus random vs reference model)
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  int checks   = 0;
  int failures = 0;

  // reference state: architectural values and pending-write flags
  logic [31:0] mreg  [NREGS];
  logic        mbusy [NREGS];

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_addr    = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    flush      = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int w, input int a, input logic [31:0] d);
    wr_en[w]                = 1'b1;
    wr_addr[w*AW +: AW]     = AW'(a);
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  function automatic int waddr(input int w);
    return int'(wr_addr[w*AW +: AW]);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      mreg[r]  = '0;
      mbusy[r] = 1'b0;
    end
  endtask

  // architectural effect of one clock edge with the current inputs
  task automatic model_edge();
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && waddr(w) != 0) mreg[waddr(w)] = wr_data[w*XLEN +: XLEN];
    if (flush) begin
      for (int r = 0; r < NREGS; r++) mbusy[r] = 1'b0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (wr_en[w]) mbusy[waddr(w)] = 1'b0;
      if (alloc_en && alloc_addr != 0) mbusy[alloc_addr] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_data(input int a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = mreg[a];
`ifdef RF_WRITE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && waddr(w) == a) v = wr_data[w*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    logic b;
    if (a == 0) return 1'b0;
    b = mbusy[a];
`ifdef RF_WRITE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && waddr(w) == a) b = alloc_en && (int'(alloc_addr) == a);
`endif
    return b;
  endfunction

  function automatic logic [31:0] exp_bvec();
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < NREGS; r++) v[r] = mbusy[r];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    idle();
    model_reset();

    // reset state
    #2;
    for (int p = 0; p < NRD; p++) set_rd(p, p + 1);
    #1;
    check("reset_rd_data", rd_data[31:0], 32'h0);
    check("reset_rd_busy", 32'(rd_busy), 32'h0);
    check("reset_busy_vec", 32'(busy_vec), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // x0 writes are dropped, zero-valued data writes are not
    set_wr(0, 0, 32'hDEADBEEF);
    step(); idle(); set_rd(0, 0); #1;
    check("x0_read", rd_data[31:0], 32'h0);
    set_wr(0, 5, 32'h1234);
    step(); idle(); set_wr(0, 5, 32'h0);
    step(); idle(); set_rd(1, 5); #1;
    check("x5_zero_write", rd_data[63:32], 32'h0);

    // dual-port collision: higher port wins
    set_wr(0, 7, 32'hAAAA); set_wr(1, 7, 32'h5555);
    step(); idle(); set_rd(2, 7); #1;
    check("collision_x7", rd_data[95:64], 32'h5555);

    // scoreboard priorities
    alloc_en = 1'b1; alloc_addr = 4'd3;
    step(); idle(); #1;
    check("alloc_x3", 32'(busy_vec[3]), 32'h1);
    alloc_en = 1'b1; alloc_addr = 4'd3; set_wr(0, 3, 32'h33);
    step(); idle(); #1;
    check("alloc_beats_write", 32'(busy_vec[3]), 32'h1);
    set_wr(1, 3, 32'h34);
    step(); idle(); #1;
    check("write_clears_x3", 32'(busy_vec[3]), 32'h0);
    alloc_en = 1'b1; alloc_addr = 4'd3;
    step(); alloc_addr = 4'd9;
    step(); idle(); #1;
    check("busy_x3_x9", 32'(busy_vec), 32'h0208);
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 4'd4;
    step(); idle(); #1;
    check("flush_drops_alloc", 32'(busy_vec), 32'h0);

    // same-cycle write/read of x10 with x10 busy
    set_wr(0, 10, 32'h11); alloc_en = 1'b1; alloc_addr = 4'd10;
    step(); idle();
    set_rd(0, 10); set_wr(1, 10, 32'hCAFE0001); #1;
`ifdef RF_WRITE_BYPASS_EN
    check("bypass_data", rd_data[31:0], 32'hCAFE0001);
    check("bypass_busy", 32'(rd_busy[0]), 32'h0);
`else
    check("nobypass_data", rd_data[31:0], 32'h11);
    check("nobypass_busy", 32'(rd_busy[0]), 32'h1);
`endif
    step(); idle(); set_rd(0, 10); #1;
    check("x10_next_cycle", rd_data[31:0], 32'hCAFE0001);
    check("x10_busy_cleared", 32'(rd_busy[0]), 32'h0);

    // asynchronous reset mid-run
    set_wr(0, 12, 32'h12121212); alloc_en = 1'b1; alloc_addr = 4'd13;
    step(); idle(); set_rd(0, 12); #1;
    check("pre_reset_x12", rd_data[31:0], 32'h12121212);
    check("pre_reset_busy", 32'(busy_vec), 32'h2000);
    rst = 1'b1; #1;
    check("async_reset_data", rd_data[31:0], 32'h0);
    check("async_reset_busy", 32'(busy_vec), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();

    // random traffic against the reference model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, NREGS - 1));
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]                = $urandom_range(0, 1);
        wr_addr[w*AW +: AW]     = AW'($urandom_range(0, NREGS - 1));
        wr_data[w*XLEN +: XLEN] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      end
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_addr = AW'($urandom_range(0, NREGS - 1));
      flush      = ($urandom_range(0, 15) == 0);
      #1;
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("rand_data_c%0d_p%0d", cyc, p), rd_data[p*XLEN +: XLEN],
              exp_data(int'(rd_addr[p*AW +: AW])));
        check($sformatf("rand_busy_c%0d_p%0d", cyc, p), 32'(rd_busy[p]),
              32'(exp_busy(int'(rd_addr[p*AW +: AW]))));
      end
      check($sformatf("rand_bvec_c%0d", cyc), 32'(busy_vec), exp_bvec());
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
